// File: rtl/decryption_pkg.sv
// Shared definitions for the Caesar decryption message path: end-of-message
// token, default widths, sequencer state encoding and counter sizing.
package decryption_pkg;

    localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

    localparam int unsigned DEFAULT_D_WIDTH   = 8;
    localparam int unsigned DEFAULT_KEY_WIDTH = 16;

    // Sequencer states, kept as plain constants for compatibility with older tools.
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t StIdle    = 2'd0;
    localparam seq_state_t StCollect = 2'd1;
    localparam seq_state_t StDrain   = 2'd2;
    localparam seq_state_t StFlush   = 2'd3;

    // Width needed to hold a count from 0 up to and including max_len.
    function automatic int unsigned cnt_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/msg_buffer.sv
// Character store for one message: DEPTH x WIDTH registers, one write port,
// one combinational read port. Contents are not reset.
module msg_buffer #(
    parameter int unsigned DEPTH = 50,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/caesar_msg_sequencer.sv
// Message-level controller for the Caesar decryption datapath. Collects a
// message up to the end token, replays it gap-free into the datapath with the
// key latched on the first character, and forwards the datapath results.
// Optional feature macro: CAESAR_SEQ_OVF_EN adds overflow flag/counter ports.
module caesar_msg_sequencer #(
    parameter int unsigned          D_WIDTH   = decryption_pkg::DEFAULT_D_WIDTH,
    parameter int unsigned          KEY_WIDTH = decryption_pkg::DEFAULT_KEY_WIDTH,
    parameter int unsigned          MAX_LEN   = 50,
    parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN =
        D_WIDTH'(decryption_pkg::START_DECRYPTION_TOKEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   core_data_o,
    output logic [KEY_WIDTH-1:0] core_key_o,
    output logic                 core_valid_o,
    input  logic [D_WIDTH-1:0]   core_data_i,
    input  logic                 core_valid_i,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
`ifdef CAESAR_SEQ_OVF_EN
    ,
    output logic                 ovf,
    output logic [7:0]           ovf_cnt
`endif
);

    import decryption_pkg::*;

    localparam int unsigned CW = cnt_width(MAX_LEN);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    seq_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        rd_q, rd_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 busy_d;
    logic                 core_valid_d;
    logic [D_WIDTH-1:0]   core_data_d;
    logic [KEY_WIDTH-1:0] core_key_d;

    logic                 is_token;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [D_WIDTH-1:0]   rd_data;
    logic                 drop;
    logic                 msg_done;

    assign is_token = (data_i == START_DECRYPTION_TOKEN);
    // Last result of the message has been forwarded.
    assign msg_done = (state_q == StFlush) && (out_cnt_q == cnt_q);

    msg_buffer #(
        .DEPTH (MAX_LEN),
        .WIDTH (D_WIDTH),
        .AW    (AW)
    ) u_msg_buffer (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (data_i),
        .raddr (rd_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Next-state: collect, drain and flush sequencing plus buffer writes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        key_d        = key_q;
        busy_d       = busy;
        core_valid_d = 1'b0;
        core_data_d  = core_data_o;
        core_key_d   = core_key_o;
        wr_en        = 1'b0;
        wr_addr      = '0;
        drop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_i && !is_token) begin
                    wr_en   = 1'b1;
                    cnt_d   = CW'(1);
                    key_d   = key;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (valid_i) begin
                    if (is_token) begin
                        rd_d    = '0;
                        busy_d  = 1'b1;
                        state_d = StDrain;
                    end else if (cnt_q < MAX_CNT) begin
                        wr_en   = 1'b1;
                        wr_addr = cnt_q[AW-1:0];
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            StDrain: begin
                core_valid_d = 1'b1;
                core_data_d  = rd_data;
                core_key_d   = key_q;
                rd_d         = rd_q + CW'(1);
                if (rd_q == cnt_q - CW'(1)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (msg_done) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Count forwarded results of the current message; cleared while idle.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (state_q == StIdle) begin
            out_cnt_d = '0;
        end else if (core_valid_i && (out_cnt_q < MAX_CNT)) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_q         <= '0;
            out_cnt_q    <= '0;
            key_q        <= '0;
            busy         <= 1'b0;
            core_valid_o <= 1'b0;
            core_data_o  <= '0;
            core_key_o   <= '0;
            data_o       <= '0;
            valid_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            out_cnt_q    <= out_cnt_d;
            key_q        <= key_d;
            busy         <= busy_d;
            core_valid_o <= core_valid_d;
            core_data_o  <= core_data_d;
            core_key_o   <= core_key_d;
            data_o       <= core_valid_i ? core_data_i : '0;
            valid_o      <= core_valid_i;
        end
    end

`ifdef CAESAR_SEQ_OVF_EN
    // Sticky per-message overflow flag and saturating lifetime drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= 8'd0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (msg_done) begin
                ovf <= 1'b0;
            end
            if (drop && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: doc/caesar_msg_sequencer.md
Name: caesar_msg_sequencer

Overview:
Message-level controller for the single-cycle Caesar decryption datapath. It collects an encrypted message one character at a time until the end token arrives, then replays the stored characters into the datapath back-to-back with a latched key. It forwards the datapath results as the decrypted stream. `busy` is asserted while a message is being processed, so upstream holds off.

Parameters:
- D_WIDTH, 8, character width.
- KEY_WIDTH, 16, key width; passed through unchanged to the datapath.
- MAX_LEN, 50, buffer depth in characters.
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message marker; never stored or decrypted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  negated reset; asynchronous, active-low.
- data_i  in  D_WIDTH  encrypted character or token.
- valid_i  in  1  data_i qualifier.
- key  in  KEY_WIDTH  shift key; sampled with the first character of a message.
- busy  out  1  high while draining; upstream must not assert valid_i.
- core_data_o  out  D_WIDTH  character issued to the datapath.
- core_key_o  out  KEY_WIDTH  latched key issued to the datapath.
- core_valid_o  out  1  issue strobe to the datapath.
- core_data_i  in  D_WIDTH  datapath result (1-cycle latency).
- core_valid_i  in  1  datapath result strobe.
- data_o  out  D_WIDTH  decrypted character.
- valid_o  out  1  data_o qualifier.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async): state=IDLE. busy, core_valid_o, valid_o = 0. core_data_o, core_key_o, data_o = 0. Counters = 0. Buffer contents don't care.
- Reset mid-operation aborts the message; no further valid_o until a new message completes.
- IDLE:
  - valid_i with data_i != token: store at buf[0], cnt=1, latch key, go to COLLECT.
  - valid_i with token: empty message; ignore and stay in IDLE.
- COLLECT:
  - valid_i with non-token and cnt<MAX_LEN: store at buf[cnt], cnt++.
  - valid_i with non-token and cnt==MAX_LEN: character dropped (overflow); cnt holds.
  - valid_i with token: go to DRAIN, rd=0; busy=1 from this same edge.
- DRAIN:
  - Each cycle: core_valid_o=1, core_data_o=buf[rd], core_key_o=latched key, rd++.
  - After issuing rd==cnt-1, go to FLUSH.
  - Issue is gap-free: cnt consecutive core_valid_o pulses.
- FLUSH: core_valid_o=0; wait until the last result has been forwarded, then go to IDLE.
- Forwarding:
  - Every edge: data_o <= core_valid_i ? core_data_i : 0, and valid_o <= core_valid_i.
  - out_cnt counts forwarded results.
- Latency: token accepted at edge T0. First core_valid_o at T0+1, first valid_o at T0+3, last valid_o at T0+cnt+2.
- busy is 1 from T0 through the cycle of the last valid_o; it is 0 from edge T0+cnt+3, where IDLE accepts the next message.
- valid_i while busy=1: ignored (protocol violation, not stored).
- Key changes after the first character: no effect on the current message.
- Width: cnt, rd and out_cnt are $clog2(MAX_LEN+1) bits. No wrap-around; full is saturating.

Optional Feature:
- Macro CAESAR_SEQ_OVF_EN.
- Defined:
  - Extra output port `ovf` (1 bit, reset 0). It is set at the edge where a character is dropped in COLLECT and stays high until that message finishes draining.
  - Cleared on the IDLE transition.
  - Also counts overflows in a saturating 8-bit register, readable on port `ovf_cnt`, which is cleared only by reset.
- Undefined: no ports; overflow characters are silently dropped.

Decomposition:
- Shared package decryption_pkg:
  - START_DECRYPTION_TOKEN.
  - Default D_WIDTH and KEY_WIDTH.
  - State encoding IDLE/COLLECT/DRAIN/FLUSH (2 bits).
  - Counter width function.
- One sub-module, msg_buffer: MAX_LEN x D_WIDTH register array with 1 write port and 1 combinational read port, no reset on contents.

Test Plan:
- key=3; send 0x4B,0x48,0x4F,0x4F,0x52 then 0xFA, with the core model as data-key.
  - Required: valid_o on 5 consecutive cycles with 0x48,0x45,0x4C,0x4C,0x4F.
  - First valid_o at token edge+3; busy drops the cycle after the last valid_o.
- Token alone in IDLE (0xFA):
  - Required: busy stays 0; no core_valid_o and no valid_o.
- Key change mid-message: key=1 on the first character 0x42, key=5 before the second 0x43, then token.
  - Required: outputs 0x41,0x42, and core_key_o=1 on both issues.
- Overflow: MAX_LEN+2 characters 0x61 then token.
  - Required: exactly MAX_LEN valid_o pulses.
  - With CAESAR_SEQ_OVF_EN: ovf=1 from the first drop until IDLE, and ovf_cnt=2.
- Reset mid-DRAIN after 2 of 5 issues, rst_n low 1 cycle:
  - Required: busy, valid_o and core_valid_o are 0 immediately (async).
  - No further outputs; a following 1-character message decrypts correctly.
- valid_i=1 with 0x55 during busy:
  - Required: ignored; the output stream is unchanged and the next message is unaffected.
